// File: rtl/surf4_pps_if.sv
// PPS control bundle: external PPS input, source select, software request,
// and the conditioned pulse plus status readback.
interface surf4_pps_if;
  logic        PPS;
  logic [1:0]  pps_sel_i;
  logic        sw_pps_i;
  logic        pps_o;
  logic [31:0] pps_count_o;
  logic [31:0] pps_period_o;
  logic        pps_missing_o;

  // Register/board side drives selection and raw PPS, reads status back.
  modport master (
    output PPS, pps_sel_i, sw_pps_i,
    input  pps_o, pps_count_o, pps_period_o, pps_missing_o
  );

  // PPS conditioning block side.
  modport slave (
    input  PPS, pps_sel_i, sw_pps_i,
    output pps_o, pps_count_o, pps_period_o, pps_missing_o
  );
endinterface

// File: rtl/surf4_pps_ctrl.sv
// SURF4 PPS conditioning and source selection.
// Synchronizes external PPS, qualifies its rising edges with a holdoff window,
// runs a flywheel 1 Hz generator phase-locked to accepted edges, tracks the
// external period and loss, and emits a registered one-cycle PPS pulse from
// the selected source together with a running pulse count.
module surf4_pps_ctrl #(
  parameter int unsigned CLK_COUNT  = 100000000,
  parameter int unsigned HOLDOFF    = 50000000,
  parameter int unsigned MISS_COUNT = 150000000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  surf4_pps_if.slave    bus
);

  localparam logic [31:0] ICNT_MAX  = 32'(CLK_COUNT - 1);
  localparam logic [31:0] HOLD_LOAD = (HOLDOFF > 0) ? 32'(HOLDOFF - 1) : 32'd0;
  localparam logic [31:0] MISS_LIM  = 32'(MISS_COUNT);
  localparam logic [31:0] SAT_MAX   = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    RUNNING    = 2'd1,
    MISSING    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sync_q, sync_d;        // [0]=s1, [1]=s2, [2]=s3
  logic [1:0]  sync_vld_q, sync_vld_d;
  logic        armed_q, armed_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] icnt_q, icnt_d;
  logic [31:0] pcnt_q, pcnt_d;
  logic [31:0] period_q, period_d;
  logic [31:0] count_q, count_d;
  logic        pps_q, pps_d;

  logic        raw_rise;
  logic        ext_acc;
  logic        int_pulse;
  logic        sel_pulse;

  // Datapath: synchronizer, edge qualification, generator, period counter, source mux.
  always_comb begin
    sync_d     = {sync_q[1:0], bus.PPS};
    // sync_vld marks which synchronizer stages hold real samples since reset,
    // so that a PPS held high through reset cannot look like a fresh edge.
    sync_vld_d = {sync_vld_q[0], 1'b1};
    armed_d    = armed_q | (sync_vld_q[1] & ~sync_q[1]);

    raw_rise   = sync_q[1] & ~sync_q[2] & armed_q;
    ext_acc    = raw_rise & (hold_q == 32'd0);

    if (ext_acc) begin
      hold_d = HOLD_LOAD;
    end else if (hold_q != 32'd0) begin
      hold_d = hold_q - 32'd1;
    end else begin
      hold_d = hold_q;
    end

    // Accepted external edge realigns the flywheel and swallows a coincident tick.
    int_pulse = 1'b0;
    if (ext_acc) begin
      icnt_d = 32'd0;
    end else if (icnt_q == ICNT_MAX) begin
      icnt_d    = 32'd0;
      int_pulse = 1'b1;
    end else begin
      icnt_d = icnt_q + 32'd1;
    end

    if (ext_acc) begin
      pcnt_d = 32'd1;
    end else if (pcnt_q == SAT_MAX) begin
      pcnt_d = pcnt_q;
    end else begin
      pcnt_d = pcnt_q + 32'd1;
    end

    case (bus.pps_sel_i)
      2'b00:   sel_pulse = ext_acc;
      2'b01:   sel_pulse = int_pulse;
      2'b10:   sel_pulse = bus.sw_pps_i;
      default: sel_pulse = 1'b0;
    endcase

    pps_d   = sel_pulse;
    count_d = count_q + {31'd0, sel_pulse};
  end

  // Loss tracking: only a gap between two edges both seen while RUNNING is a valid period.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    case (state_q)
      WAIT_FIRST: begin
        if (ext_acc) state_d = RUNNING;
      end
      RUNNING: begin
        if (ext_acc) begin
          period_d = pcnt_q;
        end else if (pcnt_d >= MISS_LIM) begin
          state_d = MISSING;
        end
      end
      MISSING: begin
        if (ext_acc) state_d = RUNNING;
      end
      default: state_d = WAIT_FIRST;
    endcase
  end

  // State register for every flop in the block.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= WAIT_FIRST;
      sync_q     <= 3'd0;
      sync_vld_q <= 2'd0;
      armed_q    <= 1'b0;
      hold_q     <= 32'd0;
      icnt_q     <= 32'd0;
      pcnt_q     <= 32'd0;
      period_q   <= 32'd0;
      count_q    <= 32'd0;
      pps_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      sync_vld_q <= sync_vld_d;
      armed_q    <= armed_d;
      hold_q     <= hold_d;
      icnt_q     <= icnt_d;
      pcnt_q     <= pcnt_d;
      period_q   <= period_d;
      count_q    <= count_d;
      pps_q      <= pps_d;
    end
  end

  assign bus.pps_o         = pps_q;
  assign bus.pps_count_o   = count_q;
  assign bus.pps_period_o  = period_q;
  assign bus.pps_missing_o = (state_q == MISSING);

endmodule

// File: tb/tb_surf4_pps_ctrl.sv
// Bench for surf4_pps_ctrl: reset/selection vector table, directed sequences
// for latency, holdoff, loss, flywheel and software/disable, then a long
// randomized run against a timeline-based reference model.
module tb_surf4_pps_ctrl;
  localparam int CLK_COUNT  = 100;
  localparam int HOLDOFF    = 20;
  localparam int MISS_COUNT = 150;

  logic clk = 1'b0;
  logic rst = 1'b1;

  surf4_pps_if bus();

  surf4_pps_ctrl #(
    .CLK_COUNT (CLK_COUNT),
    .HOLDOFF   (HOLDOFF),
    .MISS_COUNT(MISS_COUNT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: edge index since reset and the times of accepted edges.
  int          n;
  bit          h1, h2, h3;     // PPS as sampled at edges n-1, n-2, n-3
  bit          have_acc;
  int          last_acc;
  logic [31:0] m_count, m_period;
  bit          m_missing, m_pps, m_acc;

  typedef struct {
    logic        rst;
    logic        pps;
    logic [1:0]  sel;
    logic        sw;
    logic        exp_o;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t tbl[17];

  int          acc_edge, at, at2, miss_at, pcd;
  logic [31:0] c0;

  function automatic vec_t mk(logic r, logic p, logic [1:0] s, logic w,
                              logic eo, logic [31:0] ec);
    vec_t v;
    v.rst = r; v.pps = p; v.sel = s; v.sw = w; v.exp_o = eo; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: an edge is accepted if the synchronized input shows a
  // genuine low->high and at least HOLDOFF cycles have passed since the last
  // acceptance; the internal tick falls every CLK_COUNT cycles after the last
  // acceptance (or after reset); loss is MISS_COUNT-1 cycles of silence.
  task automatic model_step();
    bit rise, ipulse, sel_p;
    int base;
    if (rst) begin
      n = 0; h1 = 0; h2 = 0; h3 = 0;
      have_acc = 0; last_acc = 0;
      m_count = 0; m_period = 0; m_missing = 0; m_pps = 0; m_acc = 0;
      return;
    end
    n++;
    rise  = (n >= 4) && h2 && !h3;
    m_acc = rise && (!have_acc || (n - last_acc) >= HOLDOFF);
    base  = have_acc ? last_acc : 0;
    ipulse = !m_acc && ((n - base) % CLK_COUNT == 0);
    if (m_acc) begin
      if (have_acc && (n - last_acc) <= MISS_COUNT - 1) m_period = 32'(n - last_acc);
      have_acc = 1;
      last_acc = n;
    end
    m_missing = have_acc && (n - last_acc) >= MISS_COUNT - 1;
    case (bus.pps_sel_i)
      2'b00:   sel_p = m_acc;
      2'b01:   sel_p = ipulse;
      2'b10:   sel_p = bus.sw_pps_i;
      default: sel_p = 0;
    endcase
    m_pps   = sel_p;
    m_count = m_count + 32'(sel_p);
    h3 = h2; h2 = h1; h1 = bus.PPS;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    model_step();
    chk("pps_o",         32'(bus.pps_o),         32'(m_pps));
    chk("pps_count_o",   bus.pps_count_o,        m_count);
    chk("pps_period_o",  bus.pps_period_o,       m_period);
    chk("pps_missing_o", 32'(bus.pps_missing_o), 32'(m_missing));
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cyc();
  endtask

  task automatic wait_pulse(input int maxc, output int edge_at);
    edge_at = -1;
    for (int i = 0; i < maxc; i++) begin
      cyc();
      if (bus.pps_o) begin
        edge_at = n;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.PPS = 1'b0; bus.pps_sel_i = 2'b00; bus.sw_pps_i = 1'b0;

    // Reset with PPS high, release with it still high, then software/disable/reset.
    tbl[0]  = mk(1, 1, 2'd0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 2'd0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 2'd0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 2'd0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 2'd0, 0, 0, 0);
    tbl[5]  = mk(0, 1, 2'd0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 2'd0, 0, 0, 0);
    tbl[7]  = mk(0, 1, 2'd0, 0, 0, 0);
    tbl[8]  = mk(0, 1, 2'd2, 1, 1, 1);
    tbl[9]  = mk(0, 1, 2'd2, 0, 0, 1);
    tbl[10] = mk(0, 1, 2'd3, 1, 0, 1);
    tbl[11] = mk(0, 1, 2'd2, 1, 1, 2);
    tbl[12] = mk(0, 1, 2'd2, 1, 1, 3);
    tbl[13] = mk(0, 1, 2'd1, 1, 0, 3);
    tbl[14] = mk(0, 1, 2'd0, 1, 0, 3);
    tbl[15] = mk(1, 1, 2'd2, 1, 0, 0);
    tbl[16] = mk(0, 1, 2'd0, 0, 0, 0);

    rst = 1'b1;
    run(3);
    for (int i = 0; i < 17; i++) begin
      rst           = tbl[i].rst;
      bus.PPS       = tbl[i].pps;
      bus.pps_sel_i = tbl[i].sel;
      bus.sw_pps_i  = tbl[i].sw;
      cyc();
      chk("tbl_pps_o", 32'(bus.pps_o), 32'(tbl[i].exp_o));
      chk("tbl_count", bus.pps_count_o, tbl[i].exp_cnt);
    end
    chk("tbl_period",  bus.pps_period_o, 0);
    chk("tbl_missing", 32'(bus.pps_missing_o), 0);

    // External source: four rises 100 cycles apart, pulse 3 edges after rise.
    rst = 1'b0; bus.pps_sel_i = 2'b00; bus.sw_pps_i = 1'b0; bus.PPS = 1'b0;
    run(10);
    for (int i = 0; i < 4; i++) begin
      bus.PPS = 1'b1;
      cyc(); chk("ext_lat_e0", 32'(bus.pps_o), 0);
      cyc(); chk("ext_lat_e1", 32'(bus.pps_o), 0);
      cyc(); chk("ext_lat_e2", 32'(bus.pps_o), 1);
      acc_edge = n;
      cyc(); chk("ext_width", 32'(bus.pps_o), 0);
      bus.PPS = 1'b0;
      if (i == 1) chk("period_100", bus.pps_period_o, 100);
      if (i < 3) run(96);
    end
    chk("count_4", bus.pps_count_o, 4);

    // Holdoff: a rise landing 10 cycles after acceptance is dropped, 25 is taken.
    run(6);
    bus.PPS = 1'b1; run(4); bus.PPS = 1'b0;
    chk("holdoff_count",  bus.pps_count_o, 4);
    chk("holdoff_period", bus.pps_period_o, 100);
    run(11);
    bus.PPS = 1'b1;
    cyc(); cyc(); cyc();
    chk("acc_25_pulse", 32'(bus.pps_o), 1);
    chk("acc_25_gap", 32'(n - acc_edge), 25);
    acc_edge = n;
    cyc(); bus.PPS = 1'b0;
    chk("period_25", bus.pps_period_o, 25);
    chk("count_5",   bus.pps_count_o, 5);

    // Loss: declared 149 cycles after the last acceptance; recovery keeps period.
    miss_at = -1;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (bus.pps_missing_o) begin
        miss_at = n - acc_edge;
        break;
      end
    end
    chk("miss_delay", 32'(miss_at), 149);
    bus.PPS = 1'b1; run(3);
    chk("recover_missing", 32'(bus.pps_missing_o), 0);
    chk("recover_period",  bus.pps_period_o, 25);
    cyc(); bus.PPS = 1'b0;

    // Flywheel: internal tick lands 100 edges after the edge where the
    // external pulse would have appeared, then keeps 100-cycle spacing.
    run(30);
    bus.pps_sel_i = 2'b01;
    bus.PPS = 1'b1;
    cyc(); cyc(); cyc();
    acc_edge = n;
    chk("sel01_no_ext", 32'(bus.pps_o), 0);
    cyc(); bus.PPS = 1'b0;
    wait_pulse(150, at);
    chk("fly_first", 32'(at - acc_edge), 100);
    wait_pulse(150, at2);
    chk("fly_spacing1", 32'(at2 - at), 100);
    wait_pulse(150, at);
    chk("fly_spacing2", 32'(at - at2), 100);

    // Software source, then disabled with both sources active.
    bus.pps_sel_i = 2'b10;
    c0 = bus.pps_count_o;
    for (int i = 0; i < 3; i++) begin
      bus.sw_pps_i = 1'b1; cyc();
      chk("sw_pulse", 32'(bus.pps_o), 1);
      bus.sw_pps_i = 1'b0; run(3);
    end
    chk("sw_count", bus.pps_count_o, c0 + 32'd3);

    bus.pps_sel_i = 2'b11;
    c0 = bus.pps_count_o;
    for (int i = 0; i < 2; i++) begin
      bus.PPS = 1'b1; bus.sw_pps_i = 1'b1;
      for (int j = 0; j < 60; j++) begin
        cyc();
        chk("dis_quiet", 32'(bus.pps_o), 0);
        if (j == 3) bus.PPS = 1'b0;
        bus.sw_pps_i = j[0];
      end
    end
    chk("dis_period", bus.pps_period_o, 60);
    chk("dis_count",  bus.pps_count_o, c0);

    // Randomized run: bursty PPS with gaps spanning holdoff, nominal and loss ranges.
    bus.sw_pps_i = 1'b0; bus.PPS = 1'b0; pcd = 10;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 199) == 0) bus.pps_sel_i = 2'($urandom_range(0, 3));
      rst          = ($urandom_range(0, 2999) == 0);
      bus.sw_pps_i = ($urandom_range(0, 9) == 0);
      if (pcd == 0) begin
        if (bus.PPS) begin
          bus.PPS = 1'b0;
          case ($urandom_range(0, 3))
            0:       pcd = int'($urandom_range(3, 25));
            1:       pcd = int'($urandom_range(80, 110));
            2:       pcd = int'($urandom_range(30, 70));
            default: pcd = int'($urandom_range(140, 220));
          endcase
        end else begin
          bus.PPS = 1'b1;
          pcd = int'($urandom_range(1, 6));
        end
      end else begin
        pcd--;
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
